// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - word-addressed RAM responder for the core data bus
// One transaction at a time with programmable wait states and sticky fault capture.
module mem_bus_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        err_clr,
    output logic        busErr,
    output logic [31:0] err_addr
);

    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [32:0] SPAN     = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic        fault_q, fault_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic [31:0] mem [DEPTH];

    logic             accept;
    logic             req_fault;
    logic             enter_from_idle;
    logic             enter_resp;
    logic             ent_we;
    logic             ent_fault;
    logic [31:0]      ent_addr;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    // 33-bit offset keeps addresses below BASE_ADDR or near the top of the map out of range
    function automatic logic addr_fault(input logic [31:0] a);
        logic [32:0] off;
        off = {1'b0, a} - {1'b0, BASE_ADDR};
        return (a[1:0] != 2'b00) || (off >= SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    always_comb begin
        accept          = (state_q == IDLE) && req_valid && req_ready_q;
        req_fault       = addr_fault(req_addr);
        enter_from_idle = accept && (WAIT_STATES == 0);
        enter_resp      = enter_from_idle || ((state_q == WAIT) && (cnt_q == 4'd0));
        ent_we          = enter_from_idle ? req_we    : we_q;
        ent_fault       = enter_from_idle ? req_fault : fault_q;
        ent_addr        = enter_from_idle ? req_addr  : addr_q;
        wr_idx          = word_idx(req_addr);
        rd_idx          = word_idx(ent_addr);
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        fault_d     = fault_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        bus_err_d   = bus_err_q;
        err_addr_d  = err_addr_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    fault_d = req_fault;
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_resp) begin
            rsp_err_d   = ent_fault;
            rsp_rdata_d = (!ent_we && !ent_fault) ? mem[rd_idx] : 32'h0;
        end

        if (err_clr) begin
            bus_err_d  = 1'b0;
            err_addr_d = 32'h0;
        end
        // A new fault beats a simultaneous clear; otherwise only the first fault is recorded
        if (enter_resp && ent_fault) begin
            bus_err_d = 1'b1;
            if (!bus_err_q || err_clr) begin
                err_addr_d = ent_addr;
            end
        end

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            fault_q     <= 1'b0;
            cnt_q       <= 4'd0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            err_addr_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            bus_err_q   <= bus_err_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // Stores commit on the accept edge, so a reset during the wait period cannot undo them
    always_ff @(posedge clk) begin
        if (accept && req_we && !req_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be[i]) begin
                    mem[wr_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busErr    = bus_err_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - directed bench for mem_bus_responder
// Three instances cover WAIT_STATES = 1, 0 and 3; sel picks the one under test.
module tb_mem_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_be = 4'h0;
    logic        rsp_ready = 1'b1;
    logic        err_clr = 1'b0;

    logic        rdy_w   [3];
    logic        vld_w   [3];
    logic [31:0] rdata_w [3];
    logic        err_w   [3];
    logic        berr_w  [3];
    logic [31:0] eaddr_w [3];

    int          sel = 0;
    logic        rdy, vld, err, berr;
    logic [31:0] rdata, eaddr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_responder #(.WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_w[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(vld_w[0]), .rsp_ready(rsp_ready), .rsp_rdata(rdata_w[0]),
        .rsp_err(err_w[0]), .err_clr(err_clr), .busErr(berr_w[0]), .err_addr(eaddr_w[0])
    );

    mem_bus_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_w[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(vld_w[1]), .rsp_ready(rsp_ready), .rsp_rdata(rdata_w[1]),
        .rsp_err(err_w[1]), .err_clr(err_clr), .busErr(berr_w[1]), .err_addr(eaddr_w[1])
    );

    mem_bus_responder #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_w[2]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(vld_w[2]), .rsp_ready(rsp_ready), .rsp_rdata(rdata_w[2]),
        .rsp_err(err_w[2]), .err_clr(err_clr), .busErr(berr_w[2]), .err_addr(eaddr_w[2])
    );

    always_comb begin
        rdy   = rdy_w[sel];
        vld   = vld_w[sel];
        rdata = rdata_w[sel];
        err   = err_w[sel];
        berr  = berr_w[sel];
        eaddr = eaddr_w[sel];
    end

    function automatic int ws_of(input int s);
        return (s == 0) ? 1 : (s == 1) ? 0 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " rsp_valid"}, vld, 0);
        chk({tag, " rsp_rdata"}, rdata, 0);
        chk({tag, " rsp_err"}, err, 0);
        chk({tag, " busErr"}, berr, 0);
        chk({tag, " err_addr"}, eaddr, 0);
    endtask

    task automatic do_reset(input int s);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        err_clr   = 1'b0;
        rsp_ready = 1'b1;
        sel       = s;
        #1;
        chk("rst req_ready", rdy, 0);
        chk_idle_outputs("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel req_ready low", rdy, 0);
        @(posedge clk);
        #1;
        chk("rel req_ready rise", rdy, 1);
    endtask

    // Full transaction with rsp_ready high; clr drives err_clr on the accept edge only
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err,
                        input logic clr, input string tag);
        int cyc;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        err_clr   = clr;
        cyc = 0;
        while (!rdy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " accept"}, rdy, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        err_clr   = 1'b0;
        cyc = 1;
        while (!vld && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, " latency"}, cyc, ws_of(sel) + 1);
        chk({tag, " rdata"}, rdata, exp_rdata);
        chk({tag, " err"}, err, exp_err);
        @(posedge clk);
        #1;
        chk({tag, " valid drop"}, vld, 0);
        chk({tag, " ready back"}, rdy, 1);
    endtask

    initial begin
        // WAIT_STATES = 1
        do_reset(0);
        xact(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b0, "st10");
        xact(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, "ld10");
        xact(1'b1, 32'h10, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, 1'b0, "st10 be5");
        xact(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, 1'b0, "ld10 merge");
        xact(1'b1, 32'h13, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1'b0, "st13 misal");
        chk("misal busErr", berr, 1);
        chk("misal err_addr", eaddr, 32'h13);
        xact(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, 1'b0, "ld10 unchanged");
        xact(1'b0, 32'h5000, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, "ld5000 oor");
        chk("oor busErr", berr, 1);
        chk("first err_addr kept", eaddr, 32'h13);
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("clr busErr", berr, 0);
        chk("clr err_addr", eaddr, 0);
        xact(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 1'b0, "st10 be0");
        xact(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, 1'b0, "ld10 after be0");
        xact(1'b1, 32'hFFC, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, 1'b0, "stFFC");
        xact(1'b0, 32'hFFC, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 1'b0, "ldFFC");
        xact(1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, "ld1000");
        xact(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, "ldFFFFFFFC");
        chk("range err_addr", eaddr, 32'h1000);

        // WAIT_STATES = 0: backpressure and clear/set collision
        do_reset(1);
        xact(1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 1'b0, "ws0 st40");
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h40;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("bp valid", vld, 1);
        chk("bp rdata", rdata, 32'hCAFE_F00D);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp hold valid", vld, 1);
            chk("bp hold rdata", rdata, 32'hCAFE_F00D);
            chk("bp hold ready", rdy, 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release valid", vld, 0);
        chk("bp release ready", rdy, 1);
        xact(1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, "ws0 ld1000");
        chk("ws0 err_addr", eaddr, 32'h1000);
        xact(1'b0, 32'h2000, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, "ws0 clr+fault");
        chk("set wins busErr", berr, 1);
        chk("set wins err_addr", eaddr, 32'h2000);

        // WAIT_STATES = 3: reset during the wait period
        do_reset(2);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hA5A5_A5A5;
        req_be    = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("ws3 accepted", rdy, 0);
        @(posedge clk);
        #1;
        chk("ws3 no early valid", vld, 0);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mid rst ready", rdy, 0);
            chk_idle_outputs("mid rst");
            @(negedge clk);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("post rst no rsp", vld, 0);
        end
        xact(1'b0, 32'h20, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b0, 1'b0, "ws3 ld20");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
